// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single processor-to-memory port between
// commit stores, load-buffer reads and instruction fetch. At most one read
// is outstanding; stores are fire-and-forget and never enter WAIT.
//
// Handshake: a requester holds its *_req (valid) with stable address/data
// until it sees its *_grant pulse. A grant is issued only in the same cycle
// the memory returns a nonzero mem2proc_response (ready). Read completion is
// signalled by a single-cycle *_done pulse when the returned tag matches.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [63:0] st_data,
   input  logic [1:0]  st_size,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [1:0]  ld_size,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   input  logic [3:0]  mem2proc_response,
   input  logic [3:0]  mem2proc_tag,
   input  logic [63:0] mem2proc_data,
   output logic [1:0]  proc2mem_command,
   output logic [31:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   output logic [1:0]  proc2mem_size,
   output logic        st_grant,
   output logic        ld_grant,
   output logic        if_grant,
   output logic        ld_done,
   output logic        if_done,
   output logic [63:0] rd_data,
   output logic        busy
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic [1:0] SIZE_DOUBLE = 2'd3;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic {OWN_LD, OWN_IF} owner_t;

   state_t     state, state_n;
   owner_t     owner, owner_n;
   logic [3:0] pend_tag, pend_tag_n;
   logic       squash, squash_n;
   logic [3:0] starve_cnt, starve_cnt_n;

   logic win_st, win_ld, win_if;
   logic accepted, tag_hit, starved;

   assign accepted = (mem2proc_response != 4'd0);
   assign starved  = (starve_cnt == LIMIT);
   assign tag_hit  = (state == S_WAIT) && (pend_tag != 4'd0) && (mem2proc_tag == pend_tag);
   assign rd_data  = mem2proc_data;

   // Fixed-priority arbitration in IDLE; a starved fetch jumps ahead of loads only.
   always_comb begin
      win_st = 1'b0;
      win_ld = 1'b0;
      win_if = 1'b0;
      if (state == S_IDLE) begin
         if (st_req)                  win_st = 1'b1;
         else if (if_req && starved)  win_if = 1'b1;
         else if (ld_req)             win_ld = 1'b1;
         else if (if_req)             win_if = 1'b1;
      end
   end

   // State and bookkeeping registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         owner      <= OWN_LD;
         pend_tag   <= 4'd0;
         squash     <= 1'b0;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         pend_tag   <= pend_tag_n;
         squash     <= squash_n;
         starve_cnt <= starve_cnt_n;
      end
   end

   // Next-state logic: enter WAIT on an accepted read, leave on the matching tag.
   always_comb begin
      state_n      = state;
      owner_n      = owner;
      pend_tag_n   = pend_tag;
      squash_n     = squash;
      starve_cnt_n = starve_cnt;
      case (state)
         S_IDLE: begin
            if (accepted && (win_ld || win_if)) begin
               state_n    = S_WAIT;
               owner_n    = win_if ? OWN_IF : OWN_LD;
               pend_tag_n = mem2proc_response;
               squash_n   = 1'b0;
            end
         end
         S_WAIT: begin
            if (if_flush && (owner == OWN_IF)) squash_n = 1'b1;
            if (tag_hit) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      // Fetch starvation counter runs in both states.
      if (if_grant || !if_req)   starve_cnt_n = 4'd0;
      else if (!starved)         starve_cnt_n = starve_cnt + 4'd1;
   end

   // Mealy outputs: bus command from the winner, grants on acceptance, done on tag match.
   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = 32'd0;
      proc2mem_data    = 64'd0;
      proc2mem_size    = 2'd0;
      if (win_st) begin
         proc2mem_command = BUS_STORE;
         proc2mem_addr    = st_addr;
         proc2mem_data    = st_data;
         proc2mem_size    = st_size;
      end else if (win_ld) begin
         proc2mem_command = BUS_LOAD;
         proc2mem_addr    = ld_addr;
         proc2mem_size    = ld_size;
      end else if (win_if) begin
         proc2mem_command = BUS_LOAD;
         proc2mem_addr    = if_addr;
         proc2mem_size    = SIZE_DOUBLE;
      end
      st_grant = win_st && accepted;
      ld_grant = win_ld && accepted;
      if_grant = win_if && accepted;
      ld_done  = tag_hit && (owner == OWN_LD);
      if_done  = tag_hit && (owner == OWN_IF) && !squash && !if_flush;
      busy     = (state == S_WAIT);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Each cycle: inputs are driven just
// after the rising edge, outputs are sampled on the falling edge.
// obs packs {command[1:0], st_grant, ld_grant, if_grant, ld_done, if_done, busy}.
module tb_mem_port_arbiter;

   logic        clock, reset;
   logic        st_req, ld_req, if_req, if_flush;
   logic [31:0] st_addr, ld_addr, if_addr;
   logic [63:0] st_data, mem2proc_data;
   logic [1:0]  st_size, ld_size;
   logic [3:0]  mem2proc_response, mem2proc_tag;
   logic [1:0]  proc2mem_command, proc2mem_size;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data, rd_data;
   logic        st_grant, ld_grant, if_grant, ld_done, if_done, busy;
   logic [7:0]  obs;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
      .mem2proc_data(mem2proc_data),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
      .st_grant(st_grant), .ld_grant(ld_grant), .if_grant(if_grant),
      .ld_done(ld_done), .if_done(if_done), .rd_data(rd_data), .busy(busy)
   );

   assign obs = {proc2mem_command, st_grant, ld_grant, if_grant, ld_done, if_done, busy};

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      st_req = 0; ld_req = 0; if_req = 0; if_flush = 0;
      st_addr = 0; ld_addr = 0; if_addr = 0; st_data = 0; mem2proc_data = 0;
      st_size = 0; ld_size = 0; mem2proc_response = 0; mem2proc_tag = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      next_cycle();
      next_cycle();
      reset = 0;
      @(negedge clock);
      total++; if (obs !== 8'h00) begin bad++; $display("FAIL reset_obs got=%h exp=%h", obs, 8'h00); end
      total++; if ({proc2mem_addr, proc2mem_data, proc2mem_size} !== 98'd0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", proc2mem_addr, proc2mem_data, proc2mem_size); end
   endtask

   task automatic test_store_priority();
      // c0: all three request; store wins
      next_cycle();
      clear_inputs();
      st_req = 1; ld_req = 1; if_req = 1;
      st_addr = 32'h100; st_data = 64'h1122_3344_5566_7788; st_size = 2'd2;
      ld_addr = 32'h200; ld_size = 2'd3; if_addr = 32'h300; mem2proc_response = 4'd1;
      @(negedge clock);
      total++; if (obs !== 8'hA0) begin bad++; $display("FAIL prio_c0_obs got=%h exp=%h", obs, 8'hA0); end
      total++; if (proc2mem_addr !== 32'h100 || proc2mem_data !== 64'h1122_3344_5566_7788 || proc2mem_size !== 2'd2)
         begin bad++; $display("FAIL prio_c0_bus got=%h/%h/%h exp=100/1122334455667788/2", proc2mem_addr, proc2mem_data, proc2mem_size); end
      // c1: store gone; load wins
      next_cycle();
      st_req = 0;
      @(negedge clock);
      total++; if (obs !== 8'h50) begin bad++; $display("FAIL prio_c1_obs got=%h exp=%h", obs, 8'h50); end
      total++; if (proc2mem_addr !== 32'h200 || proc2mem_data !== 64'd0 || proc2mem_size !== 2'd3)
         begin bad++; $display("FAIL prio_c1_bus got=%h/%h/%h exp=200/0/3", proc2mem_addr, proc2mem_data, proc2mem_size); end
      // c2: waiting
      next_cycle();
      ld_req = 0;
      @(negedge clock);
      total++; if (obs !== 8'h01) begin bad++; $display("FAIL prio_c2_obs got=%h exp=%h", obs, 8'h01); end
      // c3: tag 1 returns
      next_cycle();
      mem2proc_tag = 4'd1; mem2proc_data = 64'hDEAD_BEEF;
      @(negedge clock);
      total++; if (obs !== 8'h05) begin bad++; $display("FAIL prio_c3_obs got=%h exp=%h", obs, 8'h05); end
      total++; if (rd_data !== 64'hDEAD_BEEF) begin bad++; $display("FAIL prio_c3_data got=%h exp=%h", rd_data, 64'hDEAD_BEEF); end
      // c4: fetch issues
      next_cycle();
      mem2proc_tag = 0; mem2proc_data = 0;
      @(negedge clock);
      total++; if (obs !== 8'h48) begin bad++; $display("FAIL prio_c4_obs got=%h exp=%h", obs, 8'h48); end
      total++; if (proc2mem_addr !== 32'h300 || proc2mem_size !== 2'd3)
         begin bad++; $display("FAIL prio_c4_bus got=%h/%h exp=300/3", proc2mem_addr, proc2mem_size); end
      // c5: fetch data returns
      next_cycle();
      if_req = 0; mem2proc_response = 0; mem2proc_tag = 4'd1;
      @(negedge clock);
      total++; if (obs !== 8'h03) begin bad++; $display("FAIL prio_c5_obs got=%h exp=%h", obs, 8'h03); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic [3:0]  resp  [4];
      logic [7:0]  expv  [4];
      addrs = '{32'h1000, 32'h1008, 32'h1010, 32'h1010};
      resp  = '{4'd1, 4'd2, 4'd0, 4'd3};
      expv  = '{8'hA0, 8'hA0, 8'h80, 8'hA0};
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         clear_inputs();
         st_req = 1; st_addr = addrs[i]; st_data = {32'hCAFE0000, addrs[i]}; st_size = 2'd3;
         mem2proc_response = resp[i];
         @(negedge clock);
         total++; if (obs !== expv[i]) begin bad++; $display("FAIL b2b_obs_%0d got=%h exp=%h", i, obs, expv[i]); end
         total++; if (proc2mem_addr !== addrs[i] || proc2mem_data !== {32'hCAFE0000, addrs[i]})
            begin bad++; $display("FAIL b2b_bus_%0d got=%h/%h exp=%h", i, proc2mem_addr, proc2mem_data, addrs[i]); end
      end
   endtask

   task automatic test_reject_retry();
      logic [3:0] resp [7];
      logic [3:0] tag  [7];
      logic       req  [7];
      logic [7:0] expv [7];
      resp = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0};
      tag  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0};
      req  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      expv = '{8'h40, 8'h40, 8'h40, 8'h50, 8'h01, 8'h05, 8'h00};
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         clear_inputs();
         ld_req = req[i]; ld_addr = 32'h400; ld_size = 2'd2;
         mem2proc_response = resp[i]; mem2proc_tag = tag[i];
         @(negedge clock);
         total++; if (obs !== expv[i]) begin bad++; $display("FAIL retry_obs_%0d got=%h exp=%h", i, obs, expv[i]); end
      end
   endtask

   task automatic test_starvation();
      logic [7:0]  expv [12];
      logic [31:0] ea;
      expv = '{8'h50, 8'h05, 8'h50, 8'h05, 8'h48, 8'h03, 8'h50, 8'h05, 8'h50, 8'h05, 8'h48, 8'h03};
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         clear_inputs();
         ld_req = (i < 11); if_req = (i < 11);
         ld_addr = 32'h600; ld_size = 2'd3; if_addr = 32'h700;
         mem2proc_response = 4'd1;
         mem2proc_tag = (i % 2 == 1) ? 4'd1 : 4'd0;
         ea = (expv[i] == 8'h48) ? 32'h700 : (expv[i] == 8'h50) ? 32'h600 : 32'h0;
         @(negedge clock);
         total++; if (obs !== expv[i]) begin bad++; $display("FAIL starve_obs_%0d got=%h exp=%h", i, obs, expv[i]); end
         total++; if (proc2mem_addr !== ea) begin bad++; $display("FAIL starve_addr_%0d got=%h exp=%h", i, proc2mem_addr, ea); end
      end
   endtask

   task automatic test_flush();
      logic [7:0] expv [7];
      expv = '{8'h48, 8'h01, 8'h01, 8'h01, 8'h01, 8'h50, 8'h05};
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         clear_inputs();
         if_addr = 32'h500; ld_addr = 32'h580; ld_size = 2'd3;
         case (i)
            0: begin if_req = 1; mem2proc_response = 4'd7; end
            2: if_flush = 1;
            4: mem2proc_tag = 4'd7;
            5: begin ld_req = 1; mem2proc_response = 4'd2; end
            6: mem2proc_tag = 4'd2;
            default: ;
         endcase
         @(negedge clock);
         total++; if (obs !== expv[i]) begin bad++; $display("FAIL flush_obs_%0d got=%h exp=%h", i, obs, expv[i]); end
      end
   endtask

   task automatic test_wrong_tag();
      logic [7:0] expv [5];
      logic [3:0] tag  [5];
      expv = '{8'h50, 8'h01, 8'h01, 8'h05, 8'h00};
      tag  = '{4'd0, 4'd4, 4'd0, 4'd3, 4'd0};
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         clear_inputs();
         ld_req = (i == 0); ld_addr = 32'h800; mem2proc_response = (i == 0) ? 4'd3 : 4'd0;
         mem2proc_tag = tag[i];
         @(negedge clock);
         total++; if (obs !== expv[i]) begin bad++; $display("FAIL wrongtag_obs_%0d got=%h exp=%h", i, obs, expv[i]); end
      end
   endtask

   task automatic test_reset_mid_wait();
      next_cycle();
      clear_inputs();
      ld_req = 1; ld_addr = 32'h900; mem2proc_response = 4'd2;
      @(negedge clock);
      total++; if (obs !== 8'h50) begin bad++; $display("FAIL rstwait_c0_obs got=%h exp=%h", obs, 8'h50); end
      next_cycle();
      clear_inputs();
      @(negedge clock);
      total++; if (obs !== 8'h01) begin bad++; $display("FAIL rstwait_c1_obs got=%h exp=%h", obs, 8'h01); end
      next_cycle();
      reset = 1;
      next_cycle();
      reset = 0;
      @(negedge clock);
      total++; if (obs !== 8'h00) begin bad++; $display("FAIL rstwait_after_obs got=%h exp=%h", obs, 8'h00); end
      total++; if ({proc2mem_addr, proc2mem_data, proc2mem_size, rd_data} !== 162'd0) begin bad++; $display("FAIL rstwait_after_bus got=%h/%h/%h exp=0", proc2mem_addr, proc2mem_data, proc2mem_size); end
      next_cycle();
      mem2proc_tag = 4'd2;
      @(negedge clock);
      total++; if (obs !== 8'h00) begin bad++; $display("FAIL rstwait_late_tag got=%h exp=%h", obs, 8'h00); end
      next_cycle();
      clear_inputs();
      ld_req = 1; ld_addr = 32'h900; mem2proc_response = 4'd1;
      @(negedge clock);
      total++; if (obs !== 8'h50) begin bad++; $display("FAIL rstwait_reissue got=%h exp=%h", obs, 8'h50); end
      next_cycle();
      clear_inputs();
      mem2proc_tag = 4'd1;
      @(negedge clock);
      total++; if (obs !== 8'h05) begin bad++; $display("FAIL rstwait_redone got=%h exp=%h", obs, 8'h05); end
      next_cycle();
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_store_priority();
      test_back_to_back();
      test_reject_retry();
      test_starvation();
      test_flush();
      test_wrong_tag();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
